// File: rtl/codec_config.sv
// codec_config: WM8731 power-up sequencer that writes 11 control words over a 2-wire bus.
// Define CODEC_CONFIG_RETRY_EN to resend a NACKed word up to 3 times before failing.
module codec_config #(
   parameter int unsigned CLK_DIV  = 125,
   parameter logic [6:0]  DEV_ADDR = 7'h1A
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   output logic       I2C_SCLK,
   output logic       I2C_SDAT_OE,
   input  logic       I2C_SDAT_IN,
   output logic       busy,
   output logic       done,
   output logic       error,
   output logic [3:0] word_idx
);
   localparam int unsigned   CW      = $clog2(CLK_DIV);
   localparam logic [CW-1:0] DIV_MAX = CW'(CLK_DIV - 1);
   typedef enum logic [2:0] {
      S_IDLE, S_START, S_BYTE, S_ACK, S_STOP, S_GAP, S_DONE, S_ERROR
   } state_t;
   function automatic logic [15:0] tbl(input logic [3:0] i);
      case (i)
         4'd0:    tbl = 16'h1E00;
         4'd1:    tbl = 16'h0017;
         4'd2:    tbl = 16'h0217;
         4'd3:    tbl = 16'h0479;
         4'd4:    tbl = 16'h0679;
         4'd5:    tbl = 16'h0812;
         4'd6:    tbl = 16'h0A00;
         4'd7:    tbl = 16'h0C00;
         4'd8:    tbl = 16'h0E42;
         4'd9:    tbl = 16'h1000;
         default: tbl = 16'h1201;
      endcase
   endfunction
   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    ph_q, ph_d;
   logic [1:0]    byte_q, byte_d;
   logic [2:0]    bit_q, bit_d;
   logic [3:0]    widx_q, widx_d;
   logic          nack_q, nack_d;
   logic          scl_q, scl_d;
   logic          oe_q, oe_d;
   logic          tick, last, accept, sda_bit, retry_ok;
   logic [15:0]   word;
   logic [7:0]    byte_val;
   assign tick     = cnt_q == DIV_MAX;
   assign last     = tick && ph_q == 2'd3;
   assign accept   = start && (state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
   assign word     = tbl(widx_q);
   assign byte_val = byte_q == 2'd0 ? {DEV_ADDR, 1'b0} : byte_q == 2'd1 ? word[15:8] : word[7:0];
   assign sda_bit  = byte_val[~bit_q];
`ifdef CODEC_CONFIG_RETRY_EN
   logic [1:0] retry_q, retry_d;
   assign retry_ok = retry_q != 2'd3;
   always_comb begin
      retry_d = retry_q;
      if (accept)
         retry_d = 2'd0;
      else if (last && state_q == S_GAP)
         retry_d = nack_q ? retry_q + 2'd1 : 2'd0;
   end
   always_ff @(posedge clk) begin
      if (reset)
         retry_q <= 2'd0;
      else
         retry_q <= retry_d;
   end
`else
   assign retry_ok = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         ph_q    <= 2'd0;
         byte_q  <= 2'd0;
         bit_q   <= 3'd0;
         widx_q  <= 4'd0;
         nack_q  <= 1'b0;
         scl_q   <= 1'b1;
         oe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ph_q    <= ph_d;
         byte_q  <= byte_d;
         bit_q   <= bit_d;
         widx_q  <= widx_d;
         nack_q  <= nack_d;
         scl_q   <= scl_d;
         oe_q    <= oe_d;
      end
   end
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_DONE, S_ERROR: state_d = start ? S_START : state_q;
         S_START: state_d = last ? S_BYTE : state_q;
         S_BYTE:  state_d = (last && bit_q == 3'd7) ? S_ACK : state_q;
         S_ACK:   state_d = !last ? state_q : (nack_q || byte_q == 2'd2) ? S_STOP : S_BYTE;
         S_STOP:  state_d = !last ? state_q : (nack_q && !retry_ok) ? S_ERROR : S_GAP;
         S_GAP:   state_d = !last ? state_q : (!nack_q && widx_q == 4'd10) ? S_DONE : S_START;
         default: state_d = S_IDLE;
      endcase
   end
   // Sequencing counters; a NACK is latched at t2 of an ACK slot and cleared when the gap ends
   always_comb begin
      cnt_d  = (accept || tick) ? '0 : cnt_q + 1'b1;
      ph_d   = accept ? 2'd0 : tick ? ph_q + 2'd1 : ph_q;
      bit_d  = bit_q;
      byte_d = byte_q;
      widx_d = widx_q;
      nack_d = nack_q;
      if (accept) begin
         bit_d  = 3'd0;
         byte_d = 2'd0;
         widx_d = 4'd0;
         nack_d = 1'b0;
      end else if (tick && state_q == S_ACK && ph_q == 2'd2) begin
         nack_d = I2C_SDAT_IN;
      end else if (last && state_q == S_BYTE) begin
         bit_d = bit_q + 3'd1;
      end else if (last && state_q == S_ACK) begin
         byte_d = byte_q + 2'd1;
      end else if (last && state_q == S_GAP) begin
         byte_d = 2'd0;
         nack_d = 1'b0;
         widx_d = (nack_q || widx_q == 4'd10) ? widx_q : widx_q + 4'd1;
      end
   end
   always_comb begin
      scl_d = scl_q;
      oe_d  = oe_q;
      if (tick)
         case (state_q)
            S_START: begin
               scl_d = ph_q == 2'd0 ? 1'b1 : ph_q == 2'd3 ? 1'b0 : scl_q;
               oe_d  = ph_q == 2'd0 ? 1'b0 : ph_q == 2'd1 ? 1'b1 : oe_q;
            end
            S_BYTE, S_ACK: begin
               scl_d = ph_q == 2'd1 ? 1'b1 : ph_q == 2'd3 ? 1'b0 : scl_q;
               oe_d  = ph_q == 2'd0 ? (state_q == S_BYTE && !sda_bit) : oe_q;
            end
            S_STOP: begin
               scl_d = ph_q == 2'd1 ? 1'b1 : scl_q;
               oe_d  = ph_q == 2'd0 ? 1'b1 : ph_q == 2'd2 ? 1'b0 : oe_q;
            end
            default: ;
         endcase
   end
   assign I2C_SCLK    = scl_q;
   assign I2C_SDAT_OE = oe_q;
   assign busy        = !(state_q == S_IDLE || state_q == S_DONE || state_q == S_ERROR);
   assign done        = state_q == S_DONE;
   assign error       = state_q == S_ERROR;
   assign word_idx    = widx_q;
endmodule
